// File: rtl/hint_anim_ctrl_pkg.sv
// Shared definitions for the hint-sprite animation controller and its helpers.
package hint_anim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SLIDE_IN  = 2'd1,
    HOLD      = 2'd2,
    SLIDE_OUT = 2'd3
  } anim_state_t;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  // First row after the visible area: safely inside vertical blanking.
  localparam logic [8:0] DEFAULT_TICK_LINE = 9'(V_VISIBLE);

endpackage

// File: rtl/hint_anim_ctrl_frame_tick_gen.sv
// One-clock frame tick taken from the scan position, fired once per frame
// on (TICK_LINE, column 0) no matter how many clocks each pixel lasts.
module frame_tick_gen
  import hint_anim_ctrl_pkg::*;
#(
  parameter logic [8:0] TICK_LINE = DEFAULT_TICK_LINE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic       o_tick
);

  logic w_tick_raw;
  logic r_tick_raw_d;

  assign w_tick_raw = (i_y == TICK_LINE) && (i_x == 10'd0);

  // Delay the raw match by one clock so only its rising edge becomes a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_raw_d <= 1'b0;
    else        r_tick_raw_d <= w_tick_raw;
  end

  assign o_tick = w_tick_raw & ~r_tick_raw_d;

endmodule

// File: rtl/hint_anim_ctrl.sv
// Hint sprite animator: slide down, hold (optionally blinking), slide up.
// Position and visibility move only on the frame tick, so the renderer never
// sees a change mid-frame; trigger from IDLE and cancel act immediately.
// Handshake: i_trigger / i_cancel are single-clock pulses with no ready;
// o_done is a single-clock pulse when a full sequence ends, never on cancel.
module hint_anim_ctrl
  import hint_anim_ctrl_pkg::*;
#(
  parameter logic [9:0]  TARGET_X    = 10'd231,
  parameter logic [8:0]  START_Y     = 9'd0,
  parameter logic [8:0]  TARGET_Y    = 9'd120,
  parameter logic [8:0]  STEP        = 9'd4,
  parameter logic [11:0] HOLD_FRAMES = 12'd180,
  parameter logic [5:0]  BLINK_HALF  = 6'd15,
  parameter logic [8:0]  TICK_LINE   = DEFAULT_TICK_LINE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_trigger,
  input  logic       i_cancel,
  output logic [9:0] o_posx,
  output logic [8:0] o_posy,
  output logic       o_isplay,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_state
);

  anim_state_t r_state, w_state_nxt;
  logic [9:0]  r_posx;
  logic [8:0]  r_posy, w_posy_nxt;
  logic        r_isplay, w_isplay_nxt;
  logic        r_done, w_done_nxt;
  logic [11:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [5:0]  r_blink_cnt, w_blink_cnt_nxt;
  logic        r_phase, w_phase_nxt;
  logic        w_tick;
  logic [8:0]  w_dist_in;
  logic [8:0]  w_dist_out;

  frame_tick_gen #(.TICK_LINE(TICK_LINE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_x    (i_x),
    .i_y    (i_y),
    .o_tick (w_tick)
  );

  // Distances to the end rows; posy always lies between them, so no wrap.
  assign w_dist_in  = TARGET_Y - r_posy;
  assign w_dist_out = r_posy - START_Y;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_posx      <= TARGET_X;
      r_posy      <= START_Y;
      r_isplay    <= 1'b0;
      r_done      <= 1'b0;
      r_hold_cnt  <= 12'd0;
      r_blink_cnt <= 6'd0;
      r_phase     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_posx      <= TARGET_X;
      r_posy      <= w_posy_nxt;
      r_isplay    <= w_isplay_nxt;
      r_done      <= w_done_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  // Next-state and next-datapath logic; cancel overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_posy_nxt      = r_posy;
    w_isplay_nxt    = r_isplay;
    w_done_nxt      = 1'b0;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_nxt     = r_phase;
    if (i_cancel) begin
      w_state_nxt  = IDLE;
      w_posy_nxt   = START_Y;
      w_isplay_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_posy_nxt   = START_Y;
          w_isplay_nxt = 1'b0;
          if (i_trigger) begin
            w_state_nxt  = SLIDE_IN;
            w_isplay_nxt = 1'b1;
          end
        end
        SLIDE_IN: begin
          if (w_tick) begin
            if (w_dist_in <= STEP) begin
              w_posy_nxt      = TARGET_Y;
              w_hold_cnt_nxt  = 12'd0;
              w_blink_cnt_nxt = 6'd0;
              w_phase_nxt     = 1'b1;
              w_isplay_nxt    = 1'b1;
              w_state_nxt     = HOLD;
            end else begin
              w_posy_nxt = r_posy + STEP;
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            if (BLINK_HALF != 6'd0) begin
              if (r_blink_cnt == BLINK_HALF - 6'd1) begin
                w_blink_cnt_nxt = 6'd0;
                w_phase_nxt     = ~r_phase;
                w_isplay_nxt    = ~r_phase;
              end else begin
                w_blink_cnt_nxt = r_blink_cnt + 6'd1;
                w_isplay_nxt    = r_phase;
              end
            end else begin
              w_isplay_nxt = 1'b1;
            end
            w_hold_cnt_nxt = r_hold_cnt + 12'd1;
          end
          // A retrigger restarts the hold and beats a coincident exit.
          if (i_trigger) begin
            w_hold_cnt_nxt = 12'd0;
          end else if (w_tick && (r_hold_cnt == HOLD_FRAMES - 12'd1)) begin
            w_state_nxt  = SLIDE_OUT;
            w_isplay_nxt = 1'b1;
          end
        end
        SLIDE_OUT: begin
          if (i_trigger) begin
            w_state_nxt = SLIDE_IN;
          end else if (w_tick) begin
            if (w_dist_out <= STEP) begin
              w_posy_nxt   = START_Y;
              w_isplay_nxt = 1'b0;
              w_done_nxt   = 1'b1;
              w_state_nxt  = IDLE;
            end else begin
              w_posy_nxt = r_posy - STEP;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_posx   = r_posx;
  assign o_posy   = r_posy;
  assign o_isplay = r_isplay;
  assign o_busy   = (r_state != IDLE);
  assign o_done   = r_done;
  assign o_state  = r_state;

endmodule
